// File: rtl/if_stage.sv
// Instruction-fetch stage: F-stage PC register, next-PC selection and the IF/ID pipeline register.
// Redirects are resolved from the registered D-stage instruction, so the delay-slot fetch is never squashed.
module if_stage #(
   parameter logic [31:0] PC_RESET   = 32'h0000_3000,
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcen,
   input  logic        Den,
   input  logic        Dclr,
   input  logic        br,
   input  logic        jump,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic [31:0] pc8D,
   output logic        fetch_err
);

   // Window bounds carried in 33 bits so a window ending at the top of memory cannot wrap.
   localparam logic [32:0] WIN_LO = {1'b0, PC_RESET};
   localparam logic [32:0] WIN_HI = WIN_LO + 33'(IMEM_WORDS) * 33'd4 - 33'd4;

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcd_q, pcd_d;
   logic        err_q, err_d;

   logic [31:0] pcd_plus4;
   logic [31:0] br_off;
   logic [31:0] br_tgt;
   logic [31:0] jump_tgt;
   logic        fetch_ok;
   logic [31:0] fetch_word;

   always_comb begin
      pcd_plus4 = pcd_q + 32'd4;
      br_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      br_tgt    = pcd_plus4 + br_off;
      jump_tgt  = {pcd_plus4[31:28], instr_q[25:0], 2'b00};
   end

   always_comb begin
      fetch_ok   = ({1'b0, pc_q} >= WIN_LO) && ({1'b0, pc_q} <= WIN_HI) && (pc_q[1:0] == 2'b00);
      fetch_word = fetch_ok ? imem_rdata : 32'h0;
   end

   // A stalled PC ignores redirects; D is held too, so they are presented again next cycle.
   always_comb begin
      pc_d = pc_q;
      if (pcen) begin
         if (jr)
            pc_d = jr_addr;
         else if (jump)
            pc_d = jump_tgt;
         else if (br)
            pc_d = br_tgt;
         else
            pc_d = pc_q + 32'd4;
      end
   end

   always_comb begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      err_d   = err_q;
      if (Dclr) begin
         instr_d = 32'h0;
         pcd_d   = 32'h0;
      end else if (Den) begin
         instr_d = fetch_word;
         pcd_d   = pc_q;
         err_d   = err_q | ~fetch_ok;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= PC_RESET;
         instr_q <= 32'h0;
         pcd_q   <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcd_q   <= pcd_d;
         err_q   <= err_d;
      end
   end

   assign imem_addr = pc_q;
   assign instrD    = instr_q;
   assign pcD       = pcd_q;
   assign pc8D      = pcd_q + 32'd8;
   assign fetch_err = err_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each scenario queues per-cycle stimulus with its expected
// F/D state, then drains the queue one clock at a time against the DUT.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcen, Den, Dclr, br, jump, jr;
   logic [31:0] jr_addr;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instrD, pcD, pc8D;
   logic        fetch_err;

   logic [31:0] ov_addr = 32'hFFFF_FFFF;
   logic [31:0] ov_data = 32'h0;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [5:0]  ctl;   // {pcen, Den, Dclr, br, jump, jr}
      logic [31:0] jra;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] pcd;
      logic        err;
   } step_t;

   step_t sb[$];

   if_stage dut (
      .clk        (clk),
      .rst        (rst),
      .pcen       (pcen),
      .Den        (Den),
      .Dclr       (Dclr),
      .br         (br),
      .jump       (jump),
      .jr         (jr),
      .jr_addr    (jr_addr),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .instrD     (instrD),
      .pcD        (pcD),
      .pc8D       (pc8D),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   // Memory image answers every address, even outside the window, so the DUT must mask it.
   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0] ^ 16'h1234, a[15:0]};
   endfunction

   always_comb begin
      imem_rdata = pat(imem_addr);
      if (imem_addr == ov_addr)
         imem_rdata = ov_data;
   end

   function automatic step_t mk(input logic [5:0] ctl, input logic [31:0] jra, input logic [31:0] pc,
                                input logic [31:0] ins, input logic [31:0] pcd, input logic err);
      step_t s;
      s.ctl = ctl; s.jra = jra; s.pc = pc; s.ins = ins; s.pcd = pcd; s.err = err;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input step_t s);
      {pcen, Den, Dclr, br, jump, jr} = s.ctl;
      jr_addr = s.jra;
   endtask

   task automatic idle_inputs();
      {pcen, Den, Dclr, br, jump, jr} = 6'b110000;
      jr_addr = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      step_t e;
      idle_inputs();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {32'h3000, 32'h0, 32'h0, 32'h8, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_async pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=3000 instrD=0 pcD=0 pc8D=8 err=0",
                  imem_addr, instrD, pcD, pc8D, fetch_err);
      end else
         $display("reset_async pc=%h instrD=%h pcD=%h err=%b", imem_addr, instrD, pcD, fetch_err);
      // a clock edge while held in reset must not move anything
      sb.push_back(mk(6'b110000, 32'h0, 32'h3000, 32'h0, 32'h0, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(e);
         tick();
         n_cmp++;
         if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
            n_bad++;
            $display("FAIL reset_held got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                     imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
         end else
            $display("reset_held pc=%h instrD=%h pcD=%h", imem_addr, instrD, pcD);
      end
      rst = 1'b1;
   endtask

   task automatic test_sequential();
      step_t e;
      sb.push_back(mk(6'b110000, 32'h0, 32'h3004, pat(32'h3000), 32'h3000, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h3008, pat(32'h3004), 32'h3004, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h300C, pat(32'h3008), 32'h3008, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(e);
         tick();
         n_cmp++;
         if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
            n_bad++;
            $display("FAIL sequential got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                     imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
         end else
            $display("sequential pc=%h instrD=%h pcD=%h pc8D=%h", imem_addr, instrD, pcD, pc8D);
      end
   endtask

   task automatic test_stall();
      step_t e;
      do_reset();
      sb.push_back(mk(6'b110000, 32'h0, 32'h3004, pat(32'h3000), 32'h3000, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h3008, pat(32'h3004), 32'h3004, 1'b0));
      sb.push_back(mk(6'b000000, 32'h0, 32'h3008, pat(32'h3004), 32'h3004, 1'b0));
      sb.push_back(mk(6'b000000, 32'h0, 32'h3008, pat(32'h3004), 32'h3004, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h300C, pat(32'h3008), 32'h3008, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h3010, pat(32'h300C), 32'h300C, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(e);
         tick();
         n_cmp++;
         if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
            n_bad++;
            $display("FAIL stall got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                     imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
         end else
            $display("stall ctl=%b pc=%h instrD=%h pcD=%h", e.ctl, imem_addr, instrD, pcD);
      end
   endtask

   task automatic test_branch();
      step_t e;
      ov_addr = 32'h3010;
      ov_data = 32'h1000_FFFF;   // beq $0,$0,-1
      sb.push_back(mk(6'b110000, 32'h0, 32'h3014, 32'h1000_FFFF, 32'h3010, 1'b0));
      sb.push_back(mk(6'b110100, 32'h0, 32'h3010, pat(32'h3014), 32'h3014, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h3014, 32'h1000_FFFF, 32'h3010, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(e);
         tick();
         n_cmp++;
         if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
            n_bad++;
            $display("FAIL branch got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                     imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
         end else
            $display("branch ctl=%b pc=%h instrD=%h pcD=%h", e.ctl, imem_addr, instrD, pcD);
      end
   endtask

   task automatic test_priority();
      step_t e;
      sb.push_back(mk(6'b000111, 32'h3100, 32'h3014, 32'h1000_FFFF, 32'h3010, 1'b0));
      sb.push_back(mk(6'b110111, 32'h3100, 32'h3100, pat(32'h3014), 32'h3014, 1'b0));
      // jump over br: instrD=0x22203014 at pcD=0x3014 -> {0x0, 26'h2203014, 2'b00}
      sb.push_back(mk(6'b110110, 32'h3100, 32'h0880_C050, pat(32'h3100), 32'h3100, 1'b0));
      sb.push_back(mk(6'b000000, 32'h0, 32'h0880_C050, pat(32'h3100), 32'h3100, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(e);
         tick();
         n_cmp++;
         if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
            n_bad++;
            $display("FAIL priority got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                     imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
         end else
            $display("priority ctl=%b pc=%h instrD=%h pcD=%h", e.ctl, imem_addr, instrD, pcD);
      end
   endtask

   task automatic test_fetch_window();
      step_t e;
      logic [31:0] addrs [5] = '{32'h3FFC, 32'h4000, 32'h3002, 32'h2FFC, 32'h3000};
      logic        valid [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         do_reset();
         sb.push_back(mk(6'b110001, addrs[i], addrs[i], pat(32'h3000), 32'h3000, 1'b0));
         sb.push_back(mk(6'b110000, 32'h0, addrs[i] + 32'd4, valid[i] ? pat(addrs[i]) : 32'h0,
                         addrs[i], ~valid[i]));
         while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            tick();
            n_cmp++;
            if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
               n_bad++;
               $display("FAIL window got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                        imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
            end else
               $display("window target=%h pc=%h instrD=%h pcD=%h err=%b", addrs[i], imem_addr, instrD, pcD, fetch_err);
         end
      end
   endtask

   task automatic test_jr_err();
      step_t e;
      do_reset();
      sb.push_back(mk(6'b110001, 32'h5000, 32'h5000, pat(32'h3000), 32'h3000, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h5004, 32'h0, 32'h5000, 1'b1));
      sb.push_back(mk(6'b100000, 32'h0, 32'h5008, 32'h0, 32'h5000, 1'b1));
      sb.push_back(mk(6'b111000, 32'h0, 32'h500C, 32'h0, 32'h0, 1'b1));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(e);
         tick();
         n_cmp++;
         if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
            n_bad++;
            $display("FAIL jr_err got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                     imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
         end else
            $display("jr_err ctl=%b pc=%h instrD=%h pcD=%h err=%b", e.ctl, imem_addr, instrD, pcD, fetch_err);
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({fetch_err, imem_addr, instrD, pcD} !== {1'b0, 32'h3000, 32'h0, 32'h0}) begin
         n_bad++;
         $display("FAIL err_async_clear err=%b pc=%h instrD=%h pcD=%h required err=0 pc=3000 instrD=0 pcD=0",
                  fetch_err, imem_addr, instrD, pcD);
      end else
         $display("err_async_clear err=%b pc=%h", fetch_err, imem_addr);
      idle_inputs();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_flush();
      step_t e;
      sb.push_back(mk(6'b110000, 32'h0, 32'h3004, pat(32'h3000), 32'h3000, 1'b0));
      sb.push_back(mk(6'b101000, 32'h0, 32'h3008, 32'h0, 32'h0, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h300C, pat(32'h3008), 32'h3008, 1'b0));
      sb.push_back(mk(6'b011000, 32'h0, 32'h300C, 32'h0, 32'h0, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(e);
         tick();
         n_cmp++;
         if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
            n_bad++;
            $display("FAIL flush got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                     imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
         end else
            $display("flush ctl=%b pc=%h instrD=%h pcD=%h pc8D=%h", e.ctl, imem_addr, instrD, pcD, pc8D);
      end
   endtask

   task automatic test_reset_mid_redirect();
      step_t e;
      {pcen, Den, Dclr, br, jump, jr} = 6'b110001;
      jr_addr = 32'h3100;
      #2 rst = 1'b0;
      tick();
      n_cmp++;
      if (imem_addr !== 32'h3000) begin
         n_bad++;
         $display("FAIL reset_mid_redirect pc=%h required 3000", imem_addr);
      end else
         $display("reset_mid_redirect pc=%h", imem_addr);
      idle_inputs();
      rst = 1'b1;
      sb.push_back(mk(6'b110000, 32'h0, 32'h3004, pat(32'h3000), 32'h3000, 1'b0));
      sb.push_back(mk(6'b110000, 32'h0, 32'h3008, pat(32'h3004), 32'h3004, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(e);
         tick();
         n_cmp++;
         if ({imem_addr, instrD, pcD, pc8D, fetch_err} !== {e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err}) begin
            n_bad++;
            $display("FAIL after_reset got pc=%h instrD=%h pcD=%h pc8D=%h err=%b required pc=%h instrD=%h pcD=%h pc8D=%h err=%b",
                     imem_addr, instrD, pcD, pc8D, fetch_err, e.pc, e.ins, e.pcd, e.pcd + 32'd8, e.err);
         end else
            $display("after_reset pc=%h instrD=%h pcD=%h", imem_addr, instrD, pcD);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_priority();
      test_fetch_window();
      test_jr_err();
      test_flush();
      test_reset_mid_redirect();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
